// File: rtl/servo_btn_stepper_pkg.sv
// Shared types and default timing constants for the servo controller.
// The PWM stage uses the same defaults.
package servo_pkg;

    localparam int POS_W = 8;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

    typedef enum logic [1:0] {
        IDLE,
        STEP_FIRST,
        DELAY,
        REPEAT
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

endpackage

// File: rtl/servo_btn_stepper_if.sv
// Button-in / position-out bundle between the board pins, this stepper and the PWM stage.
interface servo_btn_stepper_if;
    import servo_pkg::*;

    logic [1:0]       btn;
    logic [POS_W-1:0] pos;
    logic             step_pulse;
    logic [1:0]       at_limit;

    modport master (output btn, input pos, input step_pulse, input at_limit);
    modport slave  (input btn, output pos, output step_pulse, output at_limit);
endinterface

// File: rtl/servo_btn_stepper_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Edge on which the count reaches DEBOUNCE_CYCLES: accept the new level.
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
endmodule

// File: rtl/servo_btn_stepper.sv
// Debounced up/down buttons step an 8-bit servo position with press-and-hold
// auto-repeat, saturating at POS_MIN/POS_MAX.
module servo_btn_stepper
    import servo_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [POS_W-1:0] POS_MIN         = 8'd0,
    parameter logic [POS_W-1:0] POS_MAX         = 8'd255,
    parameter logic [POS_W-1:0] POS_RESET       = 8'd128
) (
    input  logic              clk,
    input  logic              rst,
    servo_btn_stepper_if.slave bus
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);

    logic db_up, db_dn;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .btn_raw(bus.btn[0]), .level(db_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk(clk), .rst(rst), .btn_raw(bus.btn[1]), .level(db_dn)
    );

    logic up_cmd, dn_cmd, cmd_act;
    dir_t cmd_dir;

    assign up_cmd  = db_up & ~db_dn;
    assign dn_cmd  = db_dn & ~db_up;
    assign cmd_act = up_cmd | dn_cmd;
    assign cmd_dir = dn_cmd ? DIR_DN : DIR_UP;

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pulse_q, pulse_d;
    logic             step_req;

    // The first step is applied on the edge leaving IDLE, and STEP_FIRST already
    // counts down, so first step -> first repeat is exactly REPEAT_DELAY cycles.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rpt_d    = rpt_q;
        step_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_act) begin
                    step_req = 1'b1;
                    dir_d    = cmd_dir;
                    rpt_d    = RPT_DELAY_LD;
                    state_d  = STEP_FIRST;
                end
            end
            STEP_FIRST, DELAY, REPEAT: begin
                if (!cmd_act || cmd_dir != dir_q) begin
                    rpt_d   = '0;
                    state_d = IDLE;
                end else if (rpt_q == '0) begin
                    step_req = 1'b1;
                    rpt_d    = RPT_PERIOD_LD;
                    state_d  = REPEAT;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                    if (state_q == STEP_FIRST) state_d = DELAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pos_d   = pos_q;
        pulse_d = 1'b0;
        if (step_req) begin
            if (dir_d == DIR_UP && pos_q != POS_MAX) begin
                pos_d   = pos_q + 1'b1;
                pulse_d = 1'b1;
            end else if (dir_d == DIR_DN && pos_q != POS_MIN) begin
                pos_d   = pos_q - 1'b1;
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            rpt_q   <= '0;
            pos_q   <= POS_RESET;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rpt_q   <= rpt_d;
            pos_q   <= pos_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.pos        = pos_q;
    assign bus.step_pulse = pulse_q;
    assign bus.at_limit   = {pos_q == POS_MIN, pos_q == POS_MAX};
endmodule

// File: tb/tb_servo_btn_stepper.sv
// Directed bench for servo_btn_stepper with short debounce/repeat timing.
module tb_servo_btn_stepper;
    import servo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    servo_btn_stepper_if bus ();

    servo_btn_stepper #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3),
        .POS_MIN(8'd0),
        .POS_MAX(8'd255),
        .POS_RESET(8'd128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input int exp_pos);
        tick();
        chk({tag, "_pos"}, 32'(bus.pos), 32'(exp_pos));
        chk({tag, "_pulse"}, 32'(bus.step_pulse), 32'd1);
    endtask

    task automatic quiet(input string tag, input int n, input int exp_pos);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_pos"}, 32'(bus.pos), 32'(exp_pos));
            chk({tag, "_nopulse"}, 32'(bus.step_pulse), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.btn = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.btn = 2'b00;

        // Reset state
        do_reset();
        chk("rst_pos", 32'(bus.pos), 32'd128);
        chk("rst_pulse", 32'(bus.step_pulse), 32'd0);
        chk("rst_limit", 32'(bus.at_limit), 32'd0);

        // Single press: step lands on the 7th edge, exactly once
        bus.btn = 2'b01;
        quiet("single_wait", 6, 128);
        step_chk("single_step", 129);
        bus.btn = 2'b00;
        quiet("single_after", 20, 129);

        // Bounce shorter than debounce window
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.btn = 2'b01;
            quiet("bounce_hi", 2, 128);
            bus.btn = 2'b00;
            quiet("bounce_lo", 2, 128);
        end
        quiet("bounce_after", 10, 128);

        // Hold up: steps at t0, t0+10, then every 3
        do_reset();
        bus.btn = 2'b01;
        quiet("hold_wait", 6, 128);
        step_chk("hold_first", 129);
        quiet("hold_delay", 9, 129);
        step_chk("hold_rpt1", 130);
        for (int v = 131; v <= 138; v++) begin
            quiet("hold_gap", 2, v - 1);
            step_chk("hold_rpt", v);
        end
        // Release: debounced level drops 6 edges later, two more repeats land first
        bus.btn = 2'b00;
        quiet("rel_gap", 2, 138);
        step_chk("rel_late1", 139);
        quiet("rel_gap", 2, 139);
        step_chk("rel_late2", 140);
        quiet("rel_after", 10, 140);

        // Reset in the middle of auto-repeat
        do_reset();
        bus.btn = 2'b01;
        quiet("mid_wait", 6, 128);
        step_chk("mid_first", 129);
        quiet("mid_delay", 9, 129);
        step_chk("mid_rpt1", 130);
        quiet("mid_gap", 2, 130);
        step_chk("mid_rpt2", 131);
        quiet("mid_gap", 1, 131);
        rst     = 1'b1;
        bus.btn = 2'b00;
        tick();
        rst = 1'b0;
        chk("midrst_pos", 32'(bus.pos), 32'd128);
        chk("midrst_pulse", 32'(bus.step_pulse), 32'd0);
        chk("midrst_limit", 32'(bus.at_limit), 32'd0);
        quiet("midrst_after", 15, 128);

        // Saturation at POS_MAX
        do_reset();
        bus.btn = 2'b01;
        quiet("max_wait", 6, 128);
        step_chk("max_first", 129);
        quiet("max_delay", 9, 129);
        step_chk("max_rpt1", 130);
        for (int v = 131; v <= 255; v++) begin
            quiet("max_gap", 2, v - 1);
            step_chk("max_rpt", v);
        end
        quiet("max_blocked", 30, 255);
        chk("max_limit", 32'(bus.at_limit), 32'd1);
        bus.btn = 2'b00;
        quiet("max_rel", 10, 255);

        // Saturation at POS_MIN
        bus.btn = 2'b10;
        quiet("min_wait", 6, 255);
        step_chk("min_first", 254);
        quiet("min_delay", 9, 254);
        step_chk("min_rpt1", 253);
        for (int v = 252; v >= 0; v--) begin
            quiet("min_gap", 2, v + 1);
            step_chk("min_rpt", v);
        end
        quiet("min_blocked", 30, 0);
        chk("min_limit", 32'(bus.at_limit), 32'd2);
        bus.btn = 2'b00;
        quiet("min_rel", 10, 0);

        // Both buttons: no command; adding down to a held up stops stepping
        do_reset();
        bus.btn = 2'b11;
        quiet("both_held", 20, 128);
        bus.btn = 2'b00;
        quiet("both_rel", 10, 128);
        bus.btn = 2'b01;
        quiet("both_wait", 6, 128);
        step_chk("both_first", 129);
        bus.btn = 2'b11;
        quiet("both_added", 20, 129);
        chk("both_limit", 32'(bus.at_limit), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
